// File: rtl/alarm_timekeeper.sv
// -----------------------------------------------------------------------------
// alarm_timekeeper
//   Timekeeping and alarm core. Divides clk down to a 1 Hz tick, keeps a
//   24-hour HH:MM:SS clock in BCD, holds a user alarm time (HH:MM), and rings
//   (alarm_trigger high) when the running clock ticks onto the alarm time.
//
//   Optional feature macro: ALARM_SNOOZE_EN
//     defined     -> SNOOZE state and snooze counter are built, snooze honoured
//     not defined -> no SNOOZE state, snooze input ignored
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   set_time       in   1  level: edit current time (wins over set_alarm)
//   set_alarm      in   1  level: edit/show alarm time
//   inc_min        in   1  pulse: +1 minute on field being edited
//   inc_hour       in   1  pulse: +1 hour on field being edited
//   alarm_en       in   1  level: alarm armed
//   alarm_ack      in   1  pulse: stop ringing
//   snooze         in   1  pulse: snooze ringing alarm
//   bcd_out0..5    out  4  digits, 0 = seconds ones .. 5 = hours tens
//   alarm_trigger  out  1  high while ringing (registered)
//   tick_1hz       out  1  one-cycle pulse per second
// -----------------------------------------------------------------------------
module alarm_timekeeper #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  input  logic       snooze,
  output logic [3:0] bcd_out0,
  output logic [3:0] bcd_out1,
  output logic [3:0] bcd_out2,
  output logic [3:0] bcd_out3,
  output logic [3:0] bcd_out4,
  output logic [3:0] bcd_out5,
  output logic       alarm_trigger,
  output logic       tick_1hz
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);

`ifdef ALARM_SNOOZE_EN
  localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS + 1) : 1;
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECS - 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RINGING = 2'd1, S_SNOOZE = 2'd2} state_t;
`else
  localparam int unused_snooze_secs = SNOOZE_SECS;
  typedef enum logic {S_IDLE = 1'b0, S_RINGING = 1'b1} state_t;
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // Two-digit BCD increment that wraps to 00 after wrap_at (59 or 23).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] wrap_at);
    logic [7:0] r;
    if (v == wrap_at)          r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  logic [PW-1:0] presc_reg, presc_next;
  logic [7:0]    sec_reg, sec_next, min_reg, min_next, hr_reg, hr_next;
  logic [7:0]    alm_min_reg, alm_min_next, alm_hr_reg, alm_hr_next;
  logic          tick, match;
  state_t        state_reg, state_next;
  logic [RW-1:0] ring_cnt_reg, ring_cnt_next;
  logic          trigger_reg, trigger_next;
`ifdef ALARM_SNOOZE_EN
  logic [SW-1:0] snooze_cnt_reg, snooze_cnt_next;
`endif

  // Timebase, clock and alarm register updates.
  always_comb begin
    presc_next   = presc_reg;
    sec_next     = sec_reg;
    min_next     = min_reg;
    hr_next      = hr_reg;
    alm_min_next = alm_min_reg;
    alm_hr_next  = alm_hr_reg;
    tick         = 1'b0;
    if (set_time) begin
      // Clock frozen at :00 while editing; minute wrap does not carry.
      presc_next = '0;
      sec_next   = 8'h00;
      if (inc_min)  min_next = bcd_inc(min_reg, 8'h59);
      if (inc_hour) hr_next  = bcd_inc(hr_reg, 8'h23);
    end else begin
      if (presc_reg == PRESC_MAX) begin
        tick       = 1'b1;
        presc_next = '0;
        sec_next   = bcd_inc(sec_reg, 8'h59);
        if (sec_reg == 8'h59) begin
          min_next = bcd_inc(min_reg, 8'h59);
          if (min_reg == 8'h59) hr_next = bcd_inc(hr_reg, 8'h23);
        end
      end else begin
        presc_next = presc_reg + 1'b1;
      end
      if (set_alarm) begin
        if (inc_min)  alm_min_next = bcd_inc(alm_min_reg, 8'h59);
        if (inc_hour) alm_hr_next  = bcd_inc(alm_hr_reg, 8'h23);
      end
    end
  end

  // Only a running tick can land on the alarm; edits and reset never fire it.
  assign match = tick && alarm_en && !set_alarm &&
                 (hr_next == alm_hr_reg) && (min_next == alm_min_reg) &&
                 (sec_next == 8'h00);

  // FSM state register (plus the ring/snooze timers and registered trigger).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg      <= '0;
      sec_reg        <= 8'h00;
      min_reg        <= 8'h00;
      hr_reg         <= 8'h00;
      alm_min_reg    <= 8'h00;
      alm_hr_reg     <= 8'h00;
      state_reg      <= S_IDLE;
      ring_cnt_reg   <= '0;
      trigger_reg    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_reg <= '0;
`endif
    end else begin
      presc_reg      <= presc_next;
      sec_reg        <= sec_next;
      min_reg        <= min_next;
      hr_reg         <= hr_next;
      alm_min_reg    <= alm_min_next;
      alm_hr_reg     <= alm_hr_next;
      state_reg      <= state_next;
      ring_cnt_reg   <= ring_cnt_next;
      trigger_reg    <= trigger_next;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_reg <= snooze_cnt_next;
`endif
    end
  end

  // FSM next-state logic. Ack beats snooze; matches while busy are ignored.
  always_comb begin
    state_next    = state_reg;
    ring_cnt_next = ring_cnt_reg;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_next = snooze_cnt_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (match) begin
          state_next    = S_RINGING;
          ring_cnt_next = '0;
        end
      end
      S_RINGING: begin
        if (alarm_ack || !alarm_en) begin
          state_next = S_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          state_next      = S_SNOOZE;
          snooze_cnt_next = '0;
`endif
        end else if (tick) begin
          if (ring_cnt_reg == RING_LAST) state_next = S_IDLE;
          else                           ring_cnt_next = ring_cnt_reg + 1'b1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      S_SNOOZE: begin
        if (alarm_ack || !alarm_en) begin
          state_next = S_IDLE;
        end else if (tick) begin
          if (snooze_cnt_reg == SNOOZE_LAST) begin
            state_next    = S_RINGING;
            ring_cnt_next = '0;
          end else begin
            snooze_cnt_next = snooze_cnt_reg + 1'b1;
          end
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // FSM output logic: trigger is decoded from the next state and registered,
  // so it follows the state register exactly.
  always_comb begin
    trigger_next = (state_next == S_RINGING);
  end

  logic show_alarm;
  assign show_alarm    = set_alarm && !set_time;
  assign {bcd_out5, bcd_out4} = show_alarm ? alm_hr_reg  : hr_reg;
  assign {bcd_out3, bcd_out2} = show_alarm ? alm_min_reg : min_reg;
  assign {bcd_out1, bcd_out0} = show_alarm ? 8'h00       : sec_reg;
  assign alarm_trigger = trigger_reg;
  assign tick_1hz      = tick;

endmodule
